// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - segment patterns, digit slot indices and anode constants for the BCD display scanner
package bcd_display_pkg;

   // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   localparam logic [1:0] DIG_ONES    = 2'd0;
   localparam logic [1:0] DIG_TENS    = 2'd1;
   localparam logic [1:0] DIG_HUNDRED = 2'd2;

   localparam logic [2:0] AN_ALL_OFF = 3'b111;

endpackage

// File: rtl/bcd_to_seven_seg.sv
// rtl/bcd_to_seven_seg.sv - combinational BCD to active-high 7-segment decoder, dash for values above 9
module bcd_to_seven_seg
   import bcd_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - 3-digit multiplexed 7-segment scanner with per-frame snapshot,
// leading-zero blanking and a blinking done indication
module bcd_display_scanner
   import bcd_display_pkg::*;
#(
   parameter int REFRESH_DIV    = 100000,
   parameter int BLINK_FRAMES   = 125,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] ones,
   input  logic [3:0] tens,
   input  logic [3:0] hundred,
   input  logic       done,
   output logic [6:0] seg,
   output logic       dp,
   output logic [2:0] an
);

   localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [6:0] SEG_OFF_OUT = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic       DP_OFF_OUT  = SEG_ACTIVE_LOW;

   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [1:0]       dig_idx_q, dig_idx_d;
   logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             blink_on_q, blink_on_d;
   logic             done_hold_q, done_hold_d;
   logic [3:0]       shadow_ones_q, shadow_ones_d;
   logic [3:0]       shadow_tens_q, shadow_tens_d;
   logic [3:0]       shadow_hundred_q, shadow_hundred_d;
   logic [2:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             tick;
   logic             frame_end;
   logic [3:0]       cur_digit;
   logic             digit_blank;
   logic [6:0]       dec_seg;
   logic [6:0]       seg_ah;
   logic             dp_on;

   assign tick      = (pre_cnt_q == PRE_W'(REFRESH_DIV - 1));
   assign frame_end = tick && (dig_idx_q == DIG_HUNDRED);

   // Digit selection and blanking only ever look at the shadow copies
   always_comb begin
      cur_digit   = shadow_ones_q;
      digit_blank = 1'b0;
      case (dig_idx_q)
         DIG_TENS: begin
            cur_digit   = shadow_tens_q;
            digit_blank = (shadow_hundred_q == 4'd0) && (shadow_tens_q == 4'd0);
         end
         DIG_HUNDRED: begin
            cur_digit   = shadow_hundred_q;
            digit_blank = (shadow_hundred_q == 4'd0);
         end
         default: begin
            cur_digit   = shadow_ones_q;
            digit_blank = 1'b0;
         end
      endcase
   end

   bcd_to_seven_seg u_dec (
      .bcd (cur_digit),
      .seg (dec_seg)
   );

   always_comb begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);

      dig_idx_d = dig_idx_q;
      if (tick) begin
         dig_idx_d = (dig_idx_q == DIG_HUNDRED) ? DIG_ONES : dig_idx_q + 2'd1;
      end

      shadow_ones_d    = shadow_ones_q;
      shadow_tens_d    = shadow_tens_q;
      shadow_hundred_d = shadow_hundred_q;
      if (frame_end) begin
         shadow_ones_d    = ones;
         shadow_tens_d    = tens;
         shadow_hundred_d = hundred;
      end

      done_hold_d = done_hold_q | done;

      frame_cnt_d = frame_cnt_q;
      blink_on_d  = blink_on_q;
      if (done_hold_q && frame_end) begin
         if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
            frame_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FRM_W'(1);
         end
      end

      seg_ah = digit_blank ? SEG_OFF : dec_seg;
      seg_d  = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;

      an_d = AN_ALL_OFF;
      if (!digit_blank && blink_on_q) begin
         case (dig_idx_q)
            DIG_ONES:    an_d = 3'b110;
            DIG_TENS:    an_d = 3'b101;
            DIG_HUNDRED: an_d = 3'b011;
            default:     an_d = AN_ALL_OFF;
         endcase
      end

      dp_on = (dig_idx_q == DIG_ONES) && done_hold_q && blink_on_q;
      dp_d  = SEG_ACTIVE_LOW ? ~dp_on : dp_on;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt_q        <= '0;
         dig_idx_q        <= DIG_ONES;
         frame_cnt_q      <= '0;
         blink_on_q       <= 1'b1;
         done_hold_q      <= 1'b0;
         shadow_ones_q    <= 4'd0;
         shadow_tens_q    <= 4'd0;
         shadow_hundred_q <= 4'd0;
         an_q             <= AN_ALL_OFF;
         seg_q            <= SEG_OFF_OUT;
         dp_q             <= DP_OFF_OUT;
      end else begin
         pre_cnt_q        <= pre_cnt_d;
         dig_idx_q        <= dig_idx_d;
         frame_cnt_q      <= frame_cnt_d;
         blink_on_q       <= blink_on_d;
         done_hold_q      <= done_hold_d;
         shadow_ones_q    <= shadow_ones_d;
         shadow_tens_q    <= shadow_tens_d;
         shadow_hundred_q <= shadow_hundred_d;
         an_q             <= an_d;
         seg_q            <= seg_d;
         dp_q             <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
